matrix_bram_arbiter: RTL and testbench

Shares the single matrix-storage BRAM port between NUM_REQ requesters: matrix writer, matrix reader and compute engine. A requester locks the port for a whole transaction, such as a complete metadata-plus-data matrix write. Grants are issued round-robin and all BRAM-side signals are registered. Read data is routed back to the requester that issued the read.

---
 rtl/matrix_bram_arbiter_pkg.sv | 15 +
 rtl/matrix_bram_arbiter_rr_priority_picker.sv | 27 ++
 rtl/matrix_bram_arbiter.sv | 112 +++++++++++
 tb/tb_matrix_bram_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_bram_arbiter_pkg.sv
// rtl/matrix_bram_arbiter_pkg.sv - shared types and constants for the matrix BRAM arbiter
package matrix_bram_pkg;

  typedef enum logic [1:0] {
    ST_ARB,
    ST_OWNED,
    ST_DRAIN
  } arb_state_t;

  localparam int REQ_WRITER   = 0;
  localparam int REQ_READER   = 1;
  localparam int REQ_COMPUTE  = 2;
  localparam int DRAIN_CYCLES = 2;

endpackage

// File: rtl/matrix_bram_arbiter_rr_priority_picker.sv
// rtl/matrix_bram_arbiter_rr_priority_picker.sv - first set request at or after a rotating pointer
module rr_priority_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = rr_ptr;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
      cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
    end
  end

endmodule

// File: rtl/matrix_bram_arbiter.sv
// rtl/matrix_bram_arbiter.sv - round-robin transaction-locking arbiter for the shared matrix BRAM port
module matrix_bram_arbiter
  import matrix_bram_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic [IDX_W-1:0]              owner_id,
  input  logic [NUM_REQ-1:0]            rq_wr_en,
  input  logic [NUM_REQ-1:0]            rq_rd_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rq_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] rq_din,
  output logic [DATA_WIDTH-1:0]         rq_rdata,
  output logic [NUM_REQ-1:0]            rq_rvalid,
  output logic                          access_violation,
  output logic                          bram_en,
  output logic                          bram_we,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic [DATA_WIDTH-1:0]         bram_din,
  input  logic [DATA_WIDTH-1:0]         bram_dout
);

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   next_ptr;
  logic [1:0]         drain_cnt;
  logic [NUM_REQ-1:0] rd_tag;
  logic [NUM_REQ-1:0] owner_mask;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               own_wr;
  logic               own_rd;
  logic               stray;

  rr_priority_picker #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req   (req),
    .rr_ptr(rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_mask = (state == ST_OWNED) ? (NUM_REQ'(1) << owner_id) : '0;
  assign own_wr     = |(rq_wr_en & owner_mask);
  assign own_rd     = |(rq_rd_en & owner_mask);
  assign stray      = |((rq_wr_en | rq_rd_en) & ~owner_mask);
  assign next_ptr   = (owner_id == IDX_W'(NUM_REQ - 1)) ? '0 : owner_id + 1'b1;
  assign busy       = (state != ST_ARB);
  // Read data is only meaningful alongside rvalid; keep it quiet otherwise.
  assign rq_rdata   = (|rq_rvalid) ? bram_dout : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_ARB;
      rr_ptr           <= '0;
      drain_cnt        <= '0;
      owner_id         <= '0;
      grant            <= '0;
      bram_en          <= 1'b0;
      bram_we          <= 1'b0;
      bram_addr        <= '0;
      bram_din         <= '0;
      rd_tag           <= '0;
      rq_rvalid        <= '0;
      access_violation <= 1'b0;
    end else begin
      bram_en <= own_wr | own_rd;
      bram_we <= own_wr;
      if (own_wr | own_rd) begin
        bram_addr <= rq_addr[int'(owner_id)*ADDR_WIDTH +: ADDR_WIDTH];
        bram_din  <= rq_din[int'(owner_id)*DATA_WIDTH +: DATA_WIDTH];
      end
      // Tag follows the read through the BRAM's one-cycle latency; write wins a tie.
      rd_tag           <= (own_rd && !own_wr) ? owner_mask : '0;
      rq_rvalid        <= rd_tag;
      access_violation <= stray;

      case (state)
        ST_ARB: begin
          if (pick_valid) begin
            state    <= ST_OWNED;
            owner_id <= pick_idx;
            grant    <= NUM_REQ'(1) << pick_idx;
          end
        end
        ST_OWNED: begin
          if (!req[owner_id]) begin
            state     <= ST_DRAIN;
            grant     <= '0;
            rr_ptr    <= next_ptr;
            drain_cnt <= 2'(DRAIN_CYCLES - 1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 2'd0) state <= ST_ARB;
          else drain_cnt <= drain_cnt - 2'd1;
        end
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_bram_arbiter.sv
// tb/tb_matrix_bram_arbiter.sv - self-checking bench for matrix_bram_arbiter
module tb_matrix_bram_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req, grant, rq_wr_en, rq_rd_en, rq_rvalid;
  logic          busy, access_violation, bram_en, bram_we;
  logic [1:0]    owner_id;
  logic [N*AW-1:0] rq_addr;
  logic [N*DW-1:0] rq_din;
  logic [DW-1:0] rq_rdata, bram_din, bram_dout;
  logic [AW-1:0] bram_addr;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  req, wr, rd;
    logic [13:0] a0;
    logic [31:0] d0;
    logic [13:0] a2;
    logic [31:0] d2;
    logic [2:0]  grant;
    logic        busy, en, we;
    logic [13:0] addr;
    logic [31:0] din;
    logic        viol;
    logic [2:0]  rv;
    logic [31:0] rdata;
  } vec_t;

  always #5 clk = ~clk;

  matrix_bram_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .busy(busy), .owner_id(owner_id),
    .rq_wr_en(rq_wr_en), .rq_rd_en(rq_rd_en), .rq_addr(rq_addr), .rq_din(rq_din),
    .rq_rdata(rq_rdata), .rq_rvalid(rq_rvalid), .access_violation(access_violation),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout)
  );

  // BRAM model: one-cycle read latency, plus a preload path for the bench.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      else bram_dout <= mem[bram_addr];
    end
  end

  function automatic logic [31:0] preload_val(input int i);
    return (i == 5) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(i);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [89:0] snap(input logic with_data);
    return {grant, busy, owner_id, bram_en, bram_we, bram_addr, bram_din,
            access_violation, rq_rvalid, with_data ? rq_rdata : 32'h0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] r, w, d, input logic [13:0] a0, a1, a2,
                       input logic [31:0] d0, d1, d2);
    req = r; rq_wr_en = w; rq_rd_en = d;
    rq_addr = {a2, a1, a0};
    rq_din  = {d2, d1, d0};
  endtask

  task automatic idle();
    drive(3'b000, 3'b000, 3'b000, 14'h0, 14'h0, 14'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    pl_addr = a; pl_data = v;
    step();
  endtask

  task automatic wait_grant(input logic [2:0] exp, input int exp_cyc, input string name);
    int cyc = 0;
    do begin
      step();
      cyc++;
    end while (grant == 3'b000 && cyc < 20);
    check({name, "_grant"}, 128'(grant), 128'(exp));
    if (exp_cyc > 0) check({name, "_latency"}, 128'(cyc), 128'(exp_cyc));
  endtask

  task automatic run_random(input int n);
    int m_owner = -1, m_drain = 0, m_ptr = 0, m_last = 0, tag, c;
    int tag_q[$];
    logic [31:0] data_q[$];
    logic [31:0] ref_mem [16];
    logic [2:0]  r = 3'b000, w, d, e_rv, e_grant;
    logic [13:0] a [3];
    logic [31:0] dd [3];
    logic [13:0] e_addr = 14'h0;
    logic [31:0] e_din = 32'h0, rdq, e_rdata;
    logic        e_en, e_we, e_viol, e_busy;
    for (int i = 0; i < 16; i++) ref_mem[i] = preload_val(i);
    tag_q.push_back(-1);
    data_q.push_back(32'h0);
    for (int cyc = 0; cyc < n; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
        w[i]  = ($urandom_range(0, 3) == 0);
        d[i]  = ($urandom_range(0, 3) == 0);
        a[i]  = 14'($urandom_range(0, 15));
        dd[i] = $urandom;
      end
      drive(r, w, d, a[0], a[1], a[2], dd[0], dd[1], dd[2]);
      e_viol = 1'b0; e_en = 1'b0; e_we = 1'b0; tag = -1; rdq = 32'h0;
      for (int i = 0; i < N; i++) begin
        if ((w[i] | d[i]) && i != m_owner) e_viol = 1'b1;
        if ((w[i] | d[i]) && i == m_owner) begin
          e_en = 1'b1; e_we = w[i]; e_addr = a[i]; e_din = dd[i];
          if (w[i]) ref_mem[a[i][3:0]] = dd[i];
          else begin
            tag = i;
            rdq = ref_mem[a[i][3:0]];
          end
        end
      end
      tag_q.push_back(tag);
      data_q.push_back(rdq);
      if (m_owner >= 0) begin
        if (!r[m_owner]) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
          m_drain = 2;
        end
      end else if (m_drain > 0) begin
        m_drain--;
      end else begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (m_owner < 0 && r[c]) begin
            m_owner = c;
            m_last = c;
          end
        end
      end
      step();
      tag = tag_q.pop_front();
      e_rdata = data_q.pop_front();
      e_rv = (tag < 0) ? 3'b000 : 3'b001 << tag;
      e_grant = (m_owner < 0) ? 3'b000 : 3'b001 << m_owner;
      e_busy = (m_owner >= 0) || (m_drain > 0);
      check($sformatf("random_cyc%0d", cyc), 128'(snap(e_rv != 3'b000)),
            128'({e_grant, e_busy, 2'(m_last), e_en, e_we, e_addr, e_din, e_viol, e_rv,
                  (e_rv != 3'b000) ? e_rdata : 32'h0}));
    end
  endtask

  initial begin
    vec_t vt [8];
    rst_n = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    idle();
    step();
    pl_en = 1'b1;
    for (int i = 0; i < 16; i++) preload(AW'(i), preload_val(i));
    preload(14'h480, 32'h0);
    for (int i = 0; i < 4; i++) preload(14'h100 + AW'(i), 32'h0);
    pl_en = 1'b0;
    do_reset();
    check("reset_state", 128'(snap(1'b1)), 128'(0));

    vt[0] = '{3'b001, 3'b000, 3'b000, 14'h0,   32'h0,         14'h0,   32'h0,
              3'b001, 1'b1, 1'b0, 1'b0, 14'h0,   32'h0,         1'b0, 3'b000, 32'h0};
    vt[1] = '{3'b001, 3'b001, 3'b000, 14'h480, 32'h0102_0000, 14'h0,   32'h0,
              3'b001, 1'b1, 1'b1, 1'b1, 14'h480, 32'h0102_0000, 1'b0, 3'b000, 32'h0};
    vt[2] = '{3'b001, 3'b100, 3'b000, 14'h0,   32'h0,         14'h480, 32'hBAD0_BAD0,
              3'b001, 1'b1, 1'b0, 1'b0, 14'h480, 32'h0102_0000, 1'b1, 3'b000, 32'h0};
    vt[3] = '{3'b001, 3'b000, 3'b001, 14'h480, 32'h5555_0000, 14'h0,   32'h0,
              3'b001, 1'b1, 1'b1, 1'b0, 14'h480, 32'h5555_0000, 1'b0, 3'b000, 32'h0};
    vt[4] = '{3'b000, 3'b000, 3'b001, 14'h480, 32'h5555_0000, 14'h0,   32'h0,
              3'b000, 1'b1, 1'b1, 1'b0, 14'h480, 32'h5555_0000, 1'b0, 3'b001, 32'h0102_0000};
    vt[5] = '{3'b000, 3'b000, 3'b100, 14'h0,   32'h0,         14'h011, 32'h0,
              3'b000, 1'b1, 1'b0, 1'b0, 14'h480, 32'h5555_0000, 1'b1, 3'b001, 32'h0102_0000};
    vt[6] = '{3'b000, 3'b000, 3'b000, 14'h0,   32'h0,         14'h0,   32'h0,
              3'b000, 1'b0, 1'b0, 1'b0, 14'h480, 32'h5555_0000, 1'b0, 3'b000, 32'h0};
    vt[7] = '{3'b000, 3'b010, 3'b000, 14'h0,   32'h0,         14'h0,   32'h0,
              3'b000, 1'b0, 1'b0, 1'b0, 14'h480, 32'h5555_0000, 1'b1, 3'b000, 32'h0};
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].req, vt[i].wr, vt[i].rd, vt[i].a0, 14'h0, vt[i].a2, vt[i].d0, 32'h0, vt[i].d2);
      step();
      check($sformatf("vec%0d", i), 128'(snap(vt[i].rv != 3'b000)),
            128'({vt[i].grant, vt[i].busy, 2'd0, vt[i].en, vt[i].we, vt[i].addr, vt[i].din,
                  vt[i].viol, vt[i].rv, vt[i].rdata}));
    end
    check("mem_after_violation", 128'(mem[14'h480]), 128'(32'h0102_0000));

    // Contention: order 0,1,2 then the pointer skips a re-raised requester.
    do_reset();
    drive(3'b111, 3'b000, 3'b000, 14'h0, 14'h0, 14'h0, 32'h0, 32'h0, 32'h0);
    wait_grant(3'b001, 1, "cont_first");
    req = 3'b110;
    wait_grant(3'b010, 4, "cont_second");
    req = 3'b101;
    step();
    req = 3'b111;
    wait_grant(3'b100, 0, "cont_third");
    req = 3'b011;
    wait_grant(3'b001, 0, "cont_fourth");
    req = 3'b010;
    wait_grant(3'b010, 0, "cont_fifth");

    // Read routing back to requester 1.
    idle();
    step();
    req = 3'b010;
    wait_grant(3'b010, 0, "read");
    drive(3'b010, 3'b000, 3'b010, 14'h0, 14'h5, 14'h0, 32'h0, 32'h0, 32'h0);
    step();
    req = 3'b010; rq_rd_en = 3'b000;
    check("read_pins", 128'({bram_en, bram_we, bram_addr, rq_rvalid}), 128'({1'b1, 1'b0, 14'h5, 3'b000}));
    step();
    check("read_return", 128'({rq_rvalid, rq_rdata}), 128'({3'b010, 32'hDEAD_BEEF}));
    step();
    check("read_once", 128'(rq_rvalid), 128'(3'b000));
    idle();
    step();

    // Reset during the fourth write of a 2x2 matrix.
    req = 3'b001;
    wait_grant(3'b001, 0, "burst");
    for (int i = 0; i < 3; i++) begin
      drive(3'b001, 3'b001, 3'b000, 14'h100 + 14'(i), 14'h0, 14'h0, 32'hA0 + 32'(i), 32'h0, 32'h0);
      step();
    end
    drive(3'b001, 3'b001, 3'b000, 14'h103, 14'h0, 14'h0, 32'hA3, 32'h0, 32'h0);
    check("burst_we_live", 128'({bram_en, bram_we}), 128'(2'b11));
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", 128'({bram_en, bram_we, grant, busy, rq_rvalid}), 128'(0));
    drive(3'b111, 3'b000, 3'b000, 14'h0, 14'h0, 14'h0, 32'h0, 32'h0, 32'h0);
    step();
    rst_n = 1'b1;
    wait_grant(3'b001, 1, "post_reset");
    check("burst_mem_written", 128'(mem[14'h101]), 128'(32'hA1));
    check("burst_mem_lost", 128'(mem[14'h103]), 128'(32'h0));

    do_reset();
    run_random(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
